// File: rtl/serial_shift_unit.sv
// Multi-cycle shift engine: one single-bit step per clock, repeated shamt times,
// with a start/busy/done handshake toward the ALU writeback path.
module serial_shift_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state_reg,  state_next;
  logic [WIDTH-1:0] shift_reg,  shift_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [1:0]       op_reg,     op_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] left_val;
  logic [WIDTH-1:0] right_val;
  logic             fill_bit;

  // Bit shifted into the MSB on right-moving steps.
  always_comb begin
    fill_bit = 1'b0;
    case (op_reg)
      OP_SRL:  fill_bit = 1'b0;
      OP_SRA:  fill_bit = shift_reg[WIDTH-1];
      OP_ROR:  fill_bit = shift_reg[0];
      default: fill_bit = 1'b0;
    endcase
  end

  // Per-bit one-step shifter: each bit picks its left or right neighbour.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign left_val[gi] = 1'b0;
      end else begin : g_lmid
        assign left_val[gi] = shift_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign right_val[gi] = fill_bit;
      end else begin : g_rmid
        assign right_val[gi] = shift_reg[gi+1];
      end
      assign step_val[gi] = (op_reg == OP_SLL) ? left_val[gi] : right_val[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = num;
          op_next    = op;
          count_next = shamt;
          if (shamt == '0) begin
            // Zero-length shift skips SHIFT; result is the operand itself.
            state_next  = DONE;
            result_next = num;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        shift_next = step_val;
        count_next = count_reg - 1'b1;
        if (count_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_next  = DONE;
          result_next = step_val;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      count_reg  <= '0;
      op_reg     <= OP_SLL;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      result_reg <= result_next;
    end
  end

  assign result = result_reg;
  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed and randomized checks of serial_shift_unit against an arithmetic
// reference built from shift operators.
module tb_serial_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] num;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  serial_shift_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num(num),
    .shamt(shamt), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_shift(input logic [1:0] k, input logic [31:0] v,
                                            input logic [4:0] s);
    logic signed [31:0] sv;
    int n;
    sv = v;
    n  = int'(s);
    case (k)
      2'b00:   return v << n;
      2'b01:   return v >> n;
      2'b10:   return sv >>> n;
      default: return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    logic [31:0] rnd;
    rnd   = $urandom;
    op    = rnd[1:0];
    shamt = rnd[6:2];
    num   = $urandom;
  endtask

  // Waits for done; busy must be high on every cycle before it.
  task automatic wait_done(input string tag, output int idx);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        idx = i;
        break;
      end
      check({tag, " busy_wait"}, {31'b0, busy}, 32'd1);
    end
    if (idx < 0) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic finish_op(input string tag, input int idx, input logic [4:0] s,
                           input logic [31:0] exp);
    check({tag, " latency"}, idx, {27'b0, s});
    check({tag, " result"}, result, exp);
    check({tag, " busy_done"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " busy_idle"}, {31'b0, busy}, 32'd0);
    check({tag, " result_hold"}, result, exp);
    $display("txn %s: shamt=%0d result=0x%08h latency=%0d", tag, s, result, idx);
  endtask

  task automatic run_op(input string tag, input logic [1:0] k, input logic [31:0] v,
                        input logic [4:0] s, input logic [31:0] exp);
    int idx;
    @(negedge clk);
    start = 1'b1; op = k; num = v; shamt = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    wait_done(tag, idx);
    finish_op(tag, idx, s, exp);
  endtask

  initial begin
    int idx;
    int pulses;
    logic [31:0] rnd;
    logic [31:0] v;
    logic [1:0]  k;
    logic [4:0]  s;

    rst = 1'b1; start = 1'b0; op = 2'b00; num = '0; shamt = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("idle no done", pulses, 32'd0);
    $display("txn reset: result=0x%08h busy=%0b done=%0b", result, busy, done);

    // 2: longest shift
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);

    // 3: kinds
    run_op("sra4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
    run_op("sll28", 2'b00, 32'h0000_000F, 5'd28, 32'hF000_0000);
    run_op("ror1", 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);

    // 4: zero shift, then start held high
    @(negedge clk);
    start = 1'b1; op = 2'b00; num = 32'h1234_5678; shamt = 5'd0;
    @(posedge clk);
    #1;
    op = 2'b01; num = 32'hA5A5_A5A5; shamt = 5'd3;
    @(negedge clk);
    check("sll0 done", {31'b0, done}, 32'd1);
    check("sll0 result", result, 32'h1234_5678);
    check("sll0 busy", {31'b0, busy}, 32'd1);
    $display("txn sll0: shamt=0 result=0x%08h", result);
    @(negedge clk);
    check("b2b idle busy", {31'b0, busy}, 32'd0);
    check("b2b idle done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    scramble();
    wait_done("b2b srl3", idx);
    finish_op("b2b srl3", idx, 5'd3, 32'h14B4_B4B4);

    // 5: start and inputs ignored while busy
    @(negedge clk);
    start = 1'b1; op = 2'b01; num = 32'hFFFF_FFFF; shamt = 5'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("ignore busy0", {31'b0, busy}, 32'd1);
    start = 1'b1; num = 32'h0; shamt = 5'd2; op = 2'b00;
    @(negedge clk);
    check("ignore busy1", {31'b0, busy}, 32'd1);
    start = 1'b0;
    wait_done("ignore srl8", idx);
    finish_op("ignore srl8", (idx < 0) ? idx : idx + 2, 5'd8, 32'h00FF_FFFF);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("ignore extra done", pulses, 32'd0);

    // 6: reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b10; num = 32'hF000_0000; shamt = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'h0);
    rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort no done", pulses, 32'd0);
    $display("txn abort: busy=%0b done=%0b result=0x%08h", busy, done, result);
    run_op("fresh sra20", 2'b10, 32'hF000_0000, 5'd20, 32'hFFFF_FF00);

    // Randomized operations against the reference
    for (int t = 0; t < 24; t++) begin
      rnd = $urandom;
      k = rnd[1:0];
      s = rnd[6:2];
      v = $urandom;
      run_op($sformatf("rand%0d op%0d", t, k), k, v, s, ref_shift(k, v, s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
